ddr3_lane_rd_capture: RTL and testbench

Fabric-side read-capture block for one DDR3 DQ lane. It sits behind the lane's input IOD, which deserialises the pad 1:8. It trains word alignment by pulsing the IOD bit-slip against a known read-leveling pattern. Once locked, it uses the programmed read latency to gate aligned read bursts to the controller. It is the receive counterpart of the lane's transmit/DM IOD path.

---
 rtl/ddr3_phy_pkg.sv | 26 ++
 rtl/ddr3_rd_lat_pipe.sv | 60 ++++++
 rtl/ddr3_lane_rd_capture.sv | 137 +++++++++++++
 tb/tb_ddr3_lane_rd_capture.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_phy_pkg.sv
// Shared types and constants for the DDR3 lane read-capture path.
package ddr3_phy_pkg;

  // Slip attempts before training gives up (one full 1:8 rotation).
  localparam int SLIP_LIMIT = 8;

  // Width of the programmed read latency.
  localparam int RD_LAT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_COMPARE,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED,
    ST_FAIL
  } rdcap_state_e;

  // Read issue request as seen by the latency pipe.
  typedef struct packed {
    logic                vld;
    logic [RD_LAT_W-1:0] lat;
  } rd_req_t;

endpackage

// File: rtl/ddr3_rd_lat_pipe.sv
// Read-latency token pipe plus burst-window stretcher.
// A request with latency L drops a token at tap L-1; the token reaches
// tap 0 (arrival) exactly L cycles later. The window is the OR of all
// BURST_CYCLES-long bursts opened by arrivals. Shared with DQS gating.
module ddr3_rd_lat_pipe
  import ddr3_phy_pkg::*;
#(
  parameter int MAX_LAT      = 32,
  parameter int BURST_CYCLES = 1
) (
  input  logic    fab_clk,
  input  logic    arst_n,
  input  rd_req_t req,
  output logic    arrival,
  output logic    window
);

  localparam int TAP_W = $clog2(MAX_LAT);

  logic [MAX_LAT-1:0]  vld_pipe;
  logic [MAX_LAT-1:0]  ins_mask;
  logic [RD_LAT_W-1:0] lat_m1;
  logic [TAP_W-1:0]    tap;

  assign lat_m1 = req.lat - RD_LAT_W'(1);
  assign tap    = TAP_W'(lat_m1);

  // One-hot insertion point for a new token.
  always_comb begin
    ins_mask = '0;
    if (req.vld) ins_mask[tap] = 1'b1;
  end

  // Tokens march toward tap 0 one slot per cycle.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) vld_pipe <= '0;
    else         vld_pipe <= {1'b0, vld_pipe[MAX_LAT-1:1]} | ins_mask;
  end

  assign arrival = vld_pipe[0];

  generate
    if (BURST_CYCLES > 1) begin : g_stretch
      localparam int CW = $clog2(BURST_CYCLES);
      logic [CW-1:0] burst_cnt;

      // Remaining burst cycles after the arrival cycle; a new arrival reloads.
      always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n)                burst_cnt <= '0;
        else if (arrival)           burst_cnt <= CW'(BURST_CYCLES - 1);
        else if (burst_cnt != '0)   burst_cnt <= burst_cnt - CW'(1);
      end

      assign window = arrival | (burst_cnt != '0);
    end else begin : g_direct
      assign window = arrival;
    end
  endgenerate

endmodule

// File: rtl/ddr3_lane_rd_capture.sv
// Fabric-side read capture for one DDR3 DQ lane.
// Trains 1:8 word alignment by pulsing the IOD bit-slip against a known
// pattern, then gates aligned read bursts using the programmed latency.
// Optional feature: define DDR3_RDCAP_MISMATCH_CNT_EN to count failed
// compares since the last training start (saturating 8-bit).
module ddr3_lane_rd_capture
  import ddr3_phy_pkg::*;
#(
  parameter logic [7:0] TRAIN_PATTERN = 8'hB4,
  parameter int         MAX_LAT       = 32,
  parameter int         BURST_CYCLES  = 1,
  parameter int         SLIP_WAIT     = 4
) (
  input  logic                fab_clk,
  input  logic                arst_n,
  input  logic [7:0]          rx_data,
  input  logic                rd_cmd,
  input  logic [RD_LAT_W-1:0] rd_lat,
  input  logic                train_start,
  output logic                rx_bit_slip,
  output logic [7:0]          rd_data,
  output logic                rd_valid,
  output logic                train_done,
  output logic                train_fail,
  output logic [7:0]          mismatch_cnt
);

  localparam int SW_W = $clog2(SLIP_WAIT + 1);

  rdcap_state_e state;
  logic [3:0]   slip_cnt;
  logic [SW_W-1:0] settle_cnt;
  rd_req_t      req;
  logic         arrival;
  logic         window;

  assign req.vld = rd_cmd;
  assign req.lat = rd_lat;

  ddr3_rd_lat_pipe #(
    .MAX_LAT      (MAX_LAT),
    .BURST_CYCLES (BURST_CYCLES)
  ) u_lat_pipe (
    .fab_clk (fab_clk),
    .arst_n  (arst_n),
    .req     (req),
    .arrival (arrival),
    .window  (window)
  );

  // Capture the lane word inside the read window; hold it otherwise.
  // COMPARE looks at this register, i.e. the word of the arrival cycle.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (window) rd_data <= rx_data;
      rd_valid <= window && (state == ST_LOCKED);
    end
  end

  // Alignment training FSM; all outputs registered.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= ST_IDLE;
      slip_cnt    <= '0;
      settle_cnt  <= '0;
      rx_bit_slip <= 1'b0;
      train_done  <= 1'b0;
      train_fail  <= 1'b0;
    end else begin
      rx_bit_slip <= 1'b0;
      if (train_start) begin
        state      <= ST_ARM;
        slip_cnt   <= '0;
        train_done <= 1'b0;
        train_fail <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_ARM: begin
            slip_cnt   <= '0;
            train_done <= 1'b0;
            train_fail <= 1'b0;
            if (arrival) state <= ST_COMPARE;
          end
          ST_COMPARE: begin
            if (rd_data == TRAIN_PATTERN) begin
              state      <= ST_LOCKED;
              train_done <= 1'b1;
            end else begin
              state       <= ST_SLIP;
              rx_bit_slip <= 1'b1;
              slip_cnt    <= slip_cnt + 4'd1;
            end
          end
          ST_SLIP: begin
            if (slip_cnt == 4'(SLIP_LIMIT)) begin
              state      <= ST_FAIL;
              train_fail <= 1'b1;
            end else begin
              state      <= ST_SETTLE;
              settle_cnt <= SW_W'(SLIP_WAIT);
            end
          end
          ST_SETTLE: begin
            // Ignore arrivals until the IOD has settled after the slip.
            if (settle_cnt != '0) settle_cnt <= settle_cnt - SW_W'(1);
            else if (arrival)     state      <= ST_COMPARE;
          end
          ST_LOCKED, ST_FAIL: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DDR3_RDCAP_MISMATCH_CNT_EN
  logic [7:0] mis_q;

  // Saturating count of failed compares since the last training start.
  always_ff @(posedge fab_clk or negedge arst_n) begin
    if (!arst_n)
      mis_q <= '0;
    else if (train_start || state == ST_ARM)
      mis_q <= '0;
    else if (state == ST_COMPARE && rd_data != TRAIN_PATTERN && mis_q != 8'hFF)
      mis_q <= mis_q + 8'd1;
  end

  assign mismatch_cnt = mis_q;
`else
  assign mismatch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_ddr3_lane_rd_capture.sv
// Bench for ddr3_lane_rd_capture: IOD rotation model, training scenarios,
// latency/burst reference built from command issue times, reset mid-burst.
module tb_ddr3_lane_rd_capture;

  localparam int SLIP_WAIT = 4;
  localparam int BURST     = 1;
  localparam int NCYC      = 8192;
`ifdef DDR3_RDCAP_MISMATCH_CNT_EN
  localparam bit MC_EN = 1'b1;
`else
  localparam bit MC_EN = 1'b0;
`endif

  logic       fab_clk = 1'b0;
  logic       arst_n;
  logic [7:0] rx_data;
  logic       rd_cmd;
  logic [4:0] rd_lat;
  logic       train_start;
  logic       rx_bit_slip;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       train_done;
  logic       train_fail;
  logic [7:0] mismatch_cnt;

  ddr3_lane_rd_capture dut (
    .fab_clk      (fab_clk),
    .arst_n       (arst_n),
    .rx_data      (rx_data),
    .rd_cmd       (rd_cmd),
    .rd_lat       (rd_lat),
    .train_start  (train_start),
    .rx_bit_slip  (rx_bit_slip),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .train_done   (train_done),
    .train_fail   (train_fail),
    .mismatch_cnt (mismatch_cnt)
  );

  always #5 fab_clk = ~fab_clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         nslip   = 0;
  int         last_slip = -1000;
  bit         win [NCYC];
  logic [7:0] rx_hist [NCYC];
  logic [7:0] exp_hold = 8'h00;
  bit         chk_lock = 1'b0;
  bit         iod_mode = 1'b1;
  logic [7:0] iod_word = 8'hB4;
  int         iod_off  = 0;

  function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
    logic [15:0] d;
    d = {w, w} << (n % 8);
    return d[15:8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample #1 after the edge, play the IOD and check reads.
  task automatic step();
    @(posedge fab_clk);
    #1;
    cyc++;
    rd_cmd      = 1'b0;
    train_start = 1'b0;
    if (rx_bit_slip === 1'b1) begin
      chk("slip_spacing", (cyc - last_slip > SLIP_WAIT) ? 32'd1 : 32'd0, 32'd1);
      nslip++;
      last_slip = cyc;
      iod_off   = (iod_off + 7) % 8;
    end
    if (win[cyc-1]) exp_hold = rx_hist[cyc-1];
    if (chk_lock) begin
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, win[cyc-1]});
      if (win[cyc-1]) chk("rd_data", {24'd0, rd_data}, {24'd0, rx_hist[cyc-1]});
    end
    rx_data      = iod_mode ? rotl8(iod_word, iod_off) : 8'($urandom);
    rx_hist[cyc] = rx_data;
  endtask

  // Issue a read during the current cycle; its window opens lat cycles later.
  task automatic issue(input int lat);
    rd_cmd = 1'b1;
    rd_lat = 5'(lat);
    for (int k = 0; k < BURST; k++) win[cyc + lat + k] = 1'b1;
  endtask

  // Keep issuing MPR reads until training resolves (or enough slips seen).
  task automatic train(input int stop_slips, output bit timeout);
    timeout = 1'b1;
    for (int b = 0; b < 600; b++) begin
      if (cyc % 8 == 0) issue(6);
      step();
      if (train_done || train_fail || (stop_slips > 0 && nslip >= stop_slips)) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic start_training();
    train_start = 1'b1;
    step();
    nslip     = 0;
    last_slip = -1000;
  endtask

  initial begin
    bit to;
    int t0, first, cnt;

    arst_n = 1'b0; rx_data = 8'hB4; rd_cmd = 1'b0; rd_lat = 5'd1; train_start = 1'b0;
    rx_hist[0] = rx_data;
    #12;
    chk("rst_rx_bit_slip", {31'd0, rx_bit_slip}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_train_done", {31'd0, train_done}, 32'd0);
    chk("rst_train_fail", {31'd0, train_fail}, 32'd0);
    chk("rst_mismatch", {24'd0, mismatch_cnt}, 32'd0);
    @(posedge fab_clk); #1;
    arst_n = 1'b1;

    // Already aligned: no slips.
    iod_word = 8'hB4; iod_off = 0;
    start_training();
    train(0, to);
    chk("noslip_timeout", {31'd0, to}, 32'd0);
    chk("noslip_slips", nslip, 0);
    chk("noslip_done", {31'd0, train_done}, 32'd1);
    chk("noslip_fail", {31'd0, train_fail}, 32'd0);
    chk("noslip_mismatch", {24'd0, mismatch_cnt}, 32'd0);

    // IOD rotated by 3.
    iod_off = 3;
    start_training();
    train(0, to);
    chk("rot3_timeout", {31'd0, to}, 32'd0);
    chk("rot3_slips", nslip, 3);
    chk("rot3_done", {31'd0, train_done}, 32'd1);
    chk("rot3_mismatch", {24'd0, mismatch_cnt}, MC_EN ? 32'd3 : 32'd0);

    // Pattern never present.
    iod_word = 8'h00;
    start_training();
    train(0, to);
    chk("never_timeout", {31'd0, to}, 32'd0);
    chk("never_slips", nslip, 8);
    chk("never_fail", {31'd0, train_fail}, 32'd1);
    chk("never_done", {31'd0, train_done}, 32'd0);
    chk("never_mismatch", {24'd0, mismatch_cnt}, MC_EN ? 32'd8 : 32'd0);

    // Restart from SETTLE after 2 slips: full 8 slips needed again.
    start_training();
    train(2, to);
    chk("restart_pre_timeout", {31'd0, to}, 32'd0);
    step();
    start_training();
    chk("restart_fail_clr", {31'd0, train_fail}, 32'd0);
    train(0, to);
    chk("restart_timeout", {31'd0, to}, 32'd0);
    chk("restart_slips", nslip, 8);
    chk("restart_fail", {31'd0, train_fail}, 32'd1);
    chk("restart_mismatch", {24'd0, mismatch_cnt}, MC_EN ? 32'd8 : 32'd0);

    // Lock for the data tests.
    iod_word = 8'hB4; iod_off = 0;
    start_training();
    train(0, to);
    chk("lock_done", {31'd0, train_done}, 32'd1);
    for (int i = 0; i < 40; i++) step();
    chk_lock = 1'b1;

    // Back-to-back reads, latency 10.
    t0 = cyc; first = -1; cnt = 0;
    issue(10); step();
    issue(10); step();
    for (int i = 0; i < 16; i++) begin
      step();
      if (rd_valid === 1'b1) begin
        cnt++;
        if (first < 0) first = cyc - t0;
      end
    end
    chk("lat10_first", first, 11);
    chk("lat10_count", cnt, 2);

    // Maximum latency.
    t0 = cyc; first = -1;
    issue(31); step();
    for (int i = 0; i < 40; i++) begin
      step();
      if (rd_valid === 1'b1 && first < 0) first = cyc - t0;
    end
    chk("lat31_first", first, 32);

    // Random reads with random data.
    iod_mode = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) issue(int'($urandom_range(31, 1)));
      step();
    end
    for (int i = 0; i < 40; i++) step();
    chk("rd_data_hold", {24'd0, rd_data}, {24'd0, exp_hold});

    // Reset mid-burst with a long-latency token still in flight.
    t0 = cyc;
    issue(31); step();
    issue(4);  step();
    while (cyc < t0 + 6) step();
    chk("prerst_valid", {31'd0, rd_valid}, 32'd1);
    arst_n = 1'b0;
    #1;
    chk("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_mid_data", {24'd0, rd_data}, 32'd0);
    chk("rst_mid_done", {31'd0, train_done}, 32'd0);
    chk_lock = 1'b0;
    for (int i = 0; i < 64; i++) win[cyc + i] = 1'b0;
    exp_hold = 8'h00;
    #1;
    arst_n = 1'b1;

    // Retrain with the read issued in the TRAIN_START cycle.
    iod_mode = 1'b1; iod_word = 8'hB4; iod_off = 0;
    issue(1);
    start_training();
    step(); step(); step();
    chk("same_cycle_done", {31'd0, train_done}, 32'd1);
    chk_lock = 1'b1;
    while (cyc < t0 + 36) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
